reaction_arena: RTL and testbench
=================================

REACTION_ARENA -- requirements
Module: reaction_arena

Interface
REQ-001 SHALL have parameter NPLAYERS, default 2, number of player buttons (1..8).
REQ-002 SHALL have parameter TW, default 8, width of each reaction time in ticks.
REQ-003 SHALL have parameter PRESCALE, default 1000, clk cycles per tick (>=2).
REQ-004 SHALL have parameter DELAY_MIN, default 16, minimum random pre-delay in ticks (>=1).
REQ-005 SHALL have parameter DELAY_BITS, default 6, number of LFSR bits added to DELAY_MIN.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  round request, sampled each cycle.
REQ-009 btn  input  NPLAYERS  player buttons, synchronous and debounced upstream.
REQ-010 clear_best  input  1  clears best_time.
REQ-011 led  output  1  stimulus LED, high only in ARMED.
REQ-012 busy  output  1  high in WAIT and ARMED.
REQ-013 done  output  1  one-cycle pulse at round end.
REQ-014 winner  output  max(1,clog2(NPLAYERS))  index of fastest player, valid with winner_valid.
REQ-015 winner_valid  output  1  high when at least one legal capture exists in last round.
REQ-016 false_start  output  NPLAYERS  per-player early press flags of last round.
REQ-017 times  output  NPLAYERS*TW  per-player times, player i at bits [i*TW +: TW].
REQ-018 best_time  output  TW  lowest legal winning time since reset/clear.

Function
REQ-019 Button edges SHALL be btn & ~btn_q, btn_q a registered copy; only rising edges count.
REQ-020 A 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, SHALL step every cycle and never reach zero.
REQ-021 FSM states: IDLE, WAIT, ARMED, RESULT.
REQ-022 IDLE: start=1 -> WAIT; load delay = DELAY_MIN + LFSR[DELAY_BITS-1:0]; clear times, false_start, winner_valid; prescaler to 0.
REQ-023 start SHALL be ignored in WAIT, ARMED, RESULT.
REQ-024 Prescaler counts 0..PRESCALE-1; tick asserted one cycle at PRESCALE-1; reset to 0 on entry to WAIT and ARMED.
REQ-025 WAIT: delay decrements per tick; on tick with delay==1 -> ARMED, elapsed=0.
REQ-026 WAIT: rising edge on player i SHALL set false_start[i] and times[i]=all-ones; repeats no effect.
REQ-027 ARMED: elapsed increments per tick, saturating at 2^TW-1.
REQ-028 ARMED: first rising edge of non-false-started, uncaptured player i captures elapsed (pre-increment value of that cycle) into times[i].
REQ-029 Simultaneous edges from several players in one cycle SHALL each capture the same value.
REQ-030 ARMED -> RESULT when every player is captured or false-started, or elapsed saturated; uncaptured players get times=all-ones, no false_start.
REQ-031 RESULT (one cycle): winner = minimum legal captured time, ties to lowest index; winner_valid=1 if any legal capture; done=1; -> IDLE.
REQ-032 best_time SHALL load winner time in RESULT when winner_valid and value < best_time.
REQ-033 clear_best SHALL set best_time all-ones; if coincident with RESULT update, clear wins.
REQ-034 times, false_start, winner, winner_valid SHALL hold until the next round start.

Reset
REQ-035 rst_n low SHALL force IDLE immediately: led=0, busy=0, done=0, winner=0, winner_valid=0, false_start=0, times=all-ones, best_time=all-ones, prescaler=0, btn_q=0, LFSR=16'hACE1.
REQ-036 Reset mid-round SHALL abort without done pulse; first round after release behaves as from power-up.

Verification (PRESCALE=4, TW=8, NPLAYERS=2, DELAY_MIN=2, DELAY_BITS=2)
REQ-037 Reset, start pulse -> busy=1 next cycle; led rises after (2+LFSR[1:0]) ticks x 4 cycles; predicted from seed 16'hACE1.
REQ-038 Player0 presses 3 ticks after led, player1 at 5 ticks -> times={5,3}, winner=0, winner_valid=1, done one cycle, best_time=3.
REQ-039 Player1 presses during WAIT, player0 at 2 ticks -> false_start=2'b10, times[1]=255, winner=0, best_time=2.
REQ-040 Both press same cycle at 4 ticks -> times={4,4}, winner=0; no press -> elapsed saturates at 255, times={255,255}, winner_valid=0, best unchanged.
REQ-041 Start during ARMED ignored; clear_best coincident with RESULT -> best_time=255; rst_n low in ARMED -> led=0, no done, times=255.

Source files
------------

// File: rtl/reaction_arena.sv
// Multi-player reaction-time game: after a random pre-delay the LED lights, and
// each player's latency in prescaled ticks is captured. Fastest legal press wins.
module reaction_arena #(
   parameter int NPLAYERS   = 2,
   parameter int TW         = 8,
   parameter int PRESCALE   = 1000,
   parameter int DELAY_MIN  = 16,
   parameter int DELAY_BITS = 6
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               start,
   input  logic [NPLAYERS-1:0]                                btn,
   input  logic                                               clear_best,
   output logic                                               led,
   output logic                                               busy,
   output logic                                               done,
   output logic [((NPLAYERS > 1) ? $clog2(NPLAYERS) : 1)-1:0] winner,
   output logic                                               winner_valid,
   output logic [NPLAYERS-1:0]                                false_start,
   output logic [NPLAYERS*TW-1:0]                             times,
   output logic [TW-1:0]                                      best_time
);

   localparam int WW   = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
   localparam int PW   = $clog2(PRESCALE);
   localparam int DMAX = DELAY_MIN + (1 << DELAY_BITS) - 1;
   localparam int DW   = $clog2(DMAX + 1);
   localparam logic [TW-1:0] TMAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED, S_RESULT} state_t;

   state_t              state, state_n;
   logic [15:0]         lfsr;
   logic                fb;
   logic [NPLAYERS-1:0] btn_q;
   logic [NPLAYERS-1:0] rise;
   logic [NPLAYERS-1:0] cap;
   logic [NPLAYERS-1:0] cap_new;
   logic [PW-1:0]       presc;
   logic                tick;
   logic [DW-1:0]       delay;
   logic [TW-1:0]       elapsed;
   logic                sat;
   logic [WW-1:0]       win_c, win_q;
   logic [TW-1:0]       wt_c;
   logic                wv_c, wv_q;

   assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign rise    = btn & ~btn_q;
   assign tick    = (presc == PW'(PRESCALE - 1));
   assign sat     = (elapsed == TMAX);
   assign cap_new = (state == S_ARMED) ? (rise & ~cap & ~false_start) : '0;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (start) state_n = S_WAIT;
         S_WAIT:   if (tick && delay == DW'(1)) state_n = S_ARMED;
         S_ARMED:  if ((&(cap | cap_new | false_start)) || sat) state_n = S_RESULT;
         S_RESULT: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // Minimum legal captured time; strict compare keeps the lowest index on ties.
   always_comb begin
      win_c = '0;
      wt_c  = '1;
      wv_c  = 1'b0;
      for (int i = 0; i < NPLAYERS; i++) begin
         if (cap[i] && !false_start[i] && (!wv_c || times[i*TW +: TW] < wt_c)) begin
            wv_c  = 1'b1;
            wt_c  = times[i*TW +: TW];
            win_c = WW'(i);
         end
      end
   end

   assign led          = (state == S_ARMED);
   assign busy         = (state == S_WAIT) || (state == S_ARMED);
   assign done         = (state == S_RESULT);
   assign winner       = (state == S_RESULT) ? win_c : win_q;
   assign winner_valid = (state == S_RESULT) ? wv_c : wv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         lfsr        <= 16'hACE1;
         btn_q       <= '0;
         presc       <= '0;
         cap         <= '0;
         false_start <= '0;
         times       <= '1;
         win_q       <= '0;
         wv_q        <= 1'b0;
         best_time   <= '1;
      end else begin
         state <= state_n;
         lfsr  <= {lfsr[14:0], fb};
         btn_q <= btn;
         if (state_n != state && (state_n == S_WAIT || state_n == S_ARMED))
            presc <= '0;
         else if (tick)
            presc <= '0;
         else
            presc <= presc + 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  times       <= '1;
                  false_start <= '0;
                  cap         <= '0;
                  wv_q        <= 1'b0;
               end
            end
            S_WAIT: begin
               for (int i = 0; i < NPLAYERS; i++) begin
                  if (rise[i]) begin
                     false_start[i]     <= 1'b1;
                     times[i*TW +: TW]  <= '1;
                  end
               end
            end
            S_ARMED: begin
               for (int i = 0; i < NPLAYERS; i++) begin
                  if (cap_new[i]) begin
                     cap[i]            <= 1'b1;
                     times[i*TW +: TW] <= elapsed;
                  end
               end
            end
            S_RESULT: begin
               win_q <= win_c;
               wv_q  <= wv_c;
               if (wv_c && wt_c < best_time) best_time <= wt_c;
            end
            default: ;
         endcase

         if (clear_best) best_time <= '1;
      end
   end

   // Pre-delay and elapsed counters are reinitialised on every round, so no reset.
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: begin
            if (start) delay <= DW'(DELAY_MIN) + DW'(lfsr[DELAY_BITS-1:0]);
         end
         S_WAIT: begin
            if (tick) begin
               if (delay == DW'(1)) elapsed <= '0;
               else                 delay   <= delay - 1'b1;
            end
         end
         S_ARMED: begin
            if (tick && !sat) elapsed <= elapsed + 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reaction_arena.sv
// Directed bench for reaction_arena with PRESCALE=4, TW=8, two players, short delays.
module tb_reaction_arena;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  btn;
   logic        clear_best;
   logic        led;
   logic        busy;
   logic        done;
   logic [0:0]  winner;
   logic        winner_valid;
   logic [1:0]  false_start;
   logic [15:0] times;
   logic [7:0]  best_time;

   int n_chk  = 0;
   int n_pass = 0;
   logic [15:0] m_lfsr;
   int d;
   int cnt;

   reaction_arena #(
      .NPLAYERS(2), .TW(8), .PRESCALE(4), .DELAY_MIN(2), .DELAY_BITS(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .clear_best(clear_best),
      .led(led), .busy(busy), .done(done), .winner(winner),
      .winner_valid(winner_valid), .false_start(false_start), .times(times),
      .best_time(best_time)
   );

   always #5 clk = ~clk;

   // Reference LFSR from the polynomial definition, used to predict the pre-delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_round(output int dl);
      dl = 2 + int'(m_lfsr[1:0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("fs_cleared", false_start, 0);
      chk("wv_cleared", winner_valid, 0);
      chk("times_cleared", times, 16'hFFFF);
   endtask

   task automatic wait_led(input int dl, input int pre);
      int c;
      c = pre;
      while (!led && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("led_delay", c, 4 * dl);
   endtask

   task automatic chk_result(input string tag, input bit skip_wait, input logic [15:0] t,
                             input logic [1:0] fs, input logic w, input logic wv,
                             input bit clr, input logic [7:0] best);
      if (!skip_wait) @(negedge clk);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_times"}, times, t);
      chk({tag, "_fs"}, false_start, fs);
      chk({tag, "_wv"}, winner_valid, wv);
      if (wv) chk({tag, "_winner"}, winner, w);
      btn = 2'b00;
      clear_best = clr;
      @(negedge clk);
      clear_best = 1'b0;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_wv_hold"}, winner_valid, wv);
      chk({tag, "_best"}, best_time, best);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clk = 1'b0;
      rst_n = 1'b1;
      start = 1'b0;
      btn = 2'b00;
      clear_best = 1'b0;
      #2 rst_n = 1'b0;
      cycles(3);
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_winner", winner, 0);
      chk("rst_wv", winner_valid, 0);
      chk("rst_fs", false_start, 0);
      chk("rst_times", times, 16'hFFFF);
      chk("rst_best", best_time, 8'hFF);
      rst_n = 1'b1;
      cycles(2);

      // Player0 at 3 ticks, player1 at 5 ticks
      begin_round(d);
      wait_led(d, 0);
      cycles(12);
      btn = 2'b01;
      cycles(8);
      btn = 2'b11;
      chk_result("r1", 0, 16'h0503, 2'b00, 1'b0, 1'b1, 0, 8'd3);

      // Player1 false start in WAIT; its later press is ignored; player0 at 2 ticks
      begin_round(d);
      btn = 2'b10;
      @(negedge clk);
      btn = 2'b00;
      @(negedge clk);
      wait_led(d, 2);
      chk("r2_fs_in_armed", false_start, 2'b10);
      cycles(4);
      btn = 2'b10;
      cycles(4);
      btn = 2'b11;
      chk_result("r2", 0, 16'hFF02, 2'b10, 1'b0, 1'b1, 0, 8'd2);

      // Simultaneous presses at 4 ticks tie to player0; best stays at 2
      begin_round(d);
      wait_led(d, 0);
      cycles(16);
      btn = 2'b11;
      chk_result("r3", 0, 16'h0404, 2'b00, 1'b0, 1'b1, 0, 8'd2);

      // Nobody presses: elapsed saturates at 255, RESULT follows on the next cycle
      begin_round(d);
      wait_led(d, 0);
      cnt = 0;
      while (!done && cnt < 1100) begin
         @(negedge clk);
         cnt++;
      end
      chk("r4_sat_cycles", cnt, 1021);
      chk_result("r4", 1, 16'hFFFF, 2'b00, 1'b0, 1'b0, 0, 8'd2);

      // Start during ARMED ignored; clear_best coincident with a better result wins
      begin_round(d);
      wait_led(d, 0);
      cycles(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("r5_led_kept", led, 1);
      chk("r5_busy_kept", busy, 1);
      btn = 2'b11;
      chk_result("r5", 0, 16'h0101, 2'b00, 1'b0, 1'b1, 1, 8'hFF);

      // Reset while ARMED aborts the round
      begin_round(d);
      wait_led(d, 0);
      cycles(4);
      btn = 2'b01;
      @(negedge clk);
      btn = 2'b00;
      chk("r6_captured", times, 16'hFF01);
      rst_n = 1'b0;
      #1;
      chk("r6_led", led, 0);
      chk("r6_busy", busy, 0);
      chk("r6_done", done, 0);
      chk("r6_times", times, 16'hFFFF);
      chk("r6_wv", winner_valid, 0);
      cycles(2);
      chk("r6_done_hold", done, 0);
      rst_n = 1'b1;
      cycles(3);

      // First round after release follows the power-up LFSR sequence
      begin_round(d);
      wait_led(d, 0);
      cycles(8);
      btn = 2'b10;
      cycles(4);
      btn = 2'b11;
      chk_result("r7", 0, 16'h0203, 2'b00, 1'b1, 1'b1, 0, 8'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
